// File: rtl/fmul64_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fmul64_rr_scheduler
// Brief    : Shares one fixed-latency, non-stalling FP64 multiplier between two
//            requesters. Round-robin arbitration under per-requester credits,
//            registered issue, tag pipeline steering results into per-requester
//            first-word-fall-through response FIFOs.
// Options  : define FMUL64_RR_SCHED_PERF_CNT_EN to add issue/stall counters
//            (issue_cnt0_o, issue_cnt1_o, stall_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module fmul64_rr_scheduler #(
  parameter int MUL_LATENCY = 3,
  parameter int RSP_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester 0
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [63:0] req0_opa_i,
  input  logic [63:0] req0_opb_i,
  input  logic [2:0]  req0_rm_i,
  // requester 1
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [63:0] req1_opa_i,
  input  logic [63:0] req1_opb_i,
  input  logic [2:0]  req1_rm_i,
  // multiplier issue / return
  output logic        mul_valid_o,
  output logic [63:0] mul_opa_o,
  output logic [63:0] mul_opb_o,
  output logic [2:0]  mul_rm_o,
  input  logic [63:0] mul_res_i,
  input  logic [4:0]  mul_fflags_i,
  // response port 0
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [63:0] rsp0_res_o,
  output logic [4:0]  rsp0_fflags_o,
  // response port 1
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [63:0] rsp1_res_o,
  output logic [4:0]  rsp1_fflags_o
`ifdef FMUL64_RR_SCHED_PERF_CNT_EN
  ,
  output logic [31:0] issue_cnt0_o,
  output logic [31:0] issue_cnt1_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int              c_CW       = $clog2(RSP_DEPTH + 1);
  localparam int              c_PW       = $clog2(RSP_DEPTH);
  localparam logic [c_CW-1:0] c_CRED_MAX = c_CW'(RSP_DEPTH);
  localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(RSP_DEPTH - 1);

  logic [1:0]       w_req_valid;
  logic [1:0]       w_rsp_ready;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic [1:0]       w_rsp_valid;
  logic [1:0]       w_rsp_hs;
  logic [1:0]       w_fifo_wr;
  logic [1:0][68:0] w_rsp_data;

  logic             prio_q;
  logic             prio_d;

  logic             mul_valid_q;
  logic [63:0]      mul_opa_q;
  logic [63:0]      mul_opb_q;
  logic [2:0]       mul_rm_q;
  logic             issue_id_q;

  logic [MUL_LATENCY-1:0] tag_v_q;
  logic [MUL_LATENCY-1:0] tag_id_q;

  assign w_req_valid = {req1_valid_i, req0_valid_i};
  assign w_rsp_ready = {rsp1_ready_i, rsp0_ready_i};

  // Single eligible requester wins outright; a tie goes to the favoured one.
  always_comb begin
    w_grant = w_elig;
    if (&w_elig) begin
      w_grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Favour the other requester after any grant; hold when idle.
  always_comb begin
    prio_d = prio_q;
    if (|w_grant) begin
      prio_d = w_grant[0];
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Issue registers: load the winner, operands hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_valid_q <= 1'b0;
      mul_opa_q   <= '0;
      mul_opb_q   <= '0;
      mul_rm_q    <= '0;
      issue_id_q  <= 1'b0;
    end else begin
      mul_valid_q <= |w_grant;
      if (|w_grant) begin
        mul_opa_q  <= w_grant[1] ? req1_opa_i : req0_opa_i;
        mul_opb_q  <= w_grant[1] ? req1_opb_i : req0_opb_i;
        mul_rm_q   <= w_grant[1] ? req1_rm_i  : req0_rm_i;
        issue_id_q <= w_grant[1];
      end
    end
  end

  // Tag pipeline tracks which requester owns each op inside the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      tag_v_q[0]  <= mul_valid_q;
      tag_id_q[0] <= issue_id_q;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

  assign w_fifo_wr[0] = tag_v_q[MUL_LATENCY-1] && !tag_id_q[MUL_LATENCY-1];
  assign w_fifo_wr[1] = tag_v_q[MUL_LATENCY-1] &&  tag_id_q[MUL_LATENCY-1];

  generate
    for (genvar n = 0; n < 2; n++) begin : g_port
      logic [c_CW-1:0] cred_q;
      logic [c_CW-1:0] cred_d;
      logic [c_CW-1:0] cnt_q;
      logic [c_CW-1:0] cnt_d;
      logic [c_PW-1:0] wptr_q;
      logic [c_PW-1:0] rptr_q;
      logic [68:0]     mem_q [RSP_DEPTH];

      assign w_elig[n]      = w_req_valid[n] && (cred_q < c_CRED_MAX);
      assign w_rsp_valid[n] = (cnt_q != '0);
      assign w_rsp_hs[n]    = w_rsp_valid[n] && w_rsp_ready[n];
      assign w_rsp_data[n]  = mem_q[rptr_q];

      // Credits cover in-flight plus buffered results.
      always_comb begin
        cred_d = cred_q;
        case ({w_grant[n], w_rsp_hs[n]})
          2'b10:   cred_d = cred_q + 1'b1;
          2'b01:   cred_d = cred_q - 1'b1;
          default: cred_d = cred_q;
        endcase
      end

      // FIFO occupancy follows writes from the tag pipe and consumer pops.
      always_comb begin
        cnt_d = cnt_q;
        case ({w_fifo_wr[n], w_rsp_hs[n]})
          2'b10:   cnt_d = cnt_q + 1'b1;
          2'b01:   cnt_d = cnt_q - 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end

      // Response FIFO storage and pointers; a full FIFO may write and read at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cred_q <= '0;
          cnt_q  <= '0;
          wptr_q <= '0;
          rptr_q <= '0;
          for (int i = 0; i < RSP_DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else begin
          cred_q <= cred_d;
          cnt_q  <= cnt_d;
          if (w_fifo_wr[n]) begin
            mem_q[wptr_q] <= {mul_res_i, mul_fflags_i};
            wptr_q        <= (wptr_q == c_PTR_LAST) ? '0 : wptr_q + 1'b1;
          end
          if (w_rsp_hs[n]) begin
            rptr_q <= (rptr_q == c_PTR_LAST) ? '0 : rptr_q + 1'b1;
          end
        end
      end

      // Credits bound occupancy, so a write never meets a full FIFO without a pop.
      a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_fifo_wr[n] && !w_rsp_hs[n] && (cnt_q == c_CRED_MAX)));
    end
  endgenerate

  assign req0_ready_o = w_grant[0];
  assign req1_ready_o = w_grant[1];

  assign mul_valid_o = mul_valid_q;
  assign mul_opa_o   = mul_opa_q;
  assign mul_opb_o   = mul_opb_q;
  assign mul_rm_o    = mul_rm_q;

  assign rsp0_valid_o                  = w_rsp_valid[0];
  assign rsp1_valid_o                  = w_rsp_valid[1];
  assign {rsp0_res_o, rsp0_fflags_o}   = w_rsp_data[0];
  assign {rsp1_res_o, rsp1_fflags_o}   = w_rsp_data[1];

`ifdef FMUL64_RR_SCHED_PERF_CNT_EN
  logic [31:0] issue_cnt0_q;
  logic [31:0] issue_cnt1_q;
  logic [31:0] stall_cnt_q;
  logic        w_stall;

  assign w_stall = |(w_req_valid & ~w_grant);

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt0_q <= '0;
      issue_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (w_grant[0]) issue_cnt0_q <= issue_cnt0_q + 32'd1;
      if (w_grant[1]) issue_cnt1_q <= issue_cnt1_q + 32'd1;
      if (w_stall)    stall_cnt_q  <= stall_cnt_q  + 32'd1;
    end
  end

  assign issue_cnt0_o = issue_cnt0_q;
  assign issue_cnt1_o = issue_cnt1_q;
  assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
`default_nettype wire
